// File: rtl/rom_dl_loader_pkg.sv
// Shared types for the HPS download loader: FSM states, address regions and
// active-low byte-lane mask encodings.
package rom_dl_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StHold
  } state_e;

  typedef enum logic [1:0] {
    RegRom,
    RegGap,
    RegProm,
    RegOvf
  } region_e;

  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/rom_dl_loader.sv
// Turns the hps_io ioctl byte stream into program-ROM / PROM write strobes and
// holds the game in reset across the download plus a settle window.
module rom_dl_loader
  import rom_dl_loader_pkg::*;
#(
  parameter int unsigned ROM_AW      = 17,
  parameter logic [24:0] PROM_START  = 25'h40000,
  parameter int unsigned PROM_CNT    = 8,
  parameter int unsigned PROM_AW     = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                clk_sys_i,
  input  logic                reset_i,
  input  logic                ioctl_download_i,
  input  logic                ioctl_wr_i,
  input  logic [24:0]         ioctl_addr_i,
  input  logic [7:0]          ioctl_dout_i,
  output logic [ROM_AW-1:0]   prog_addr_o,
  output logic [7:0]          prog_data_o,
  output logic [1:0]          prog_mask_o,
  output logic                prog_we_o,
  output logic [PROM_AW-1:0]  prom_addr_o,
  output logic [PROM_CNT-1:0] prom_we_o,
  output logic                game_rst_o,
  output logic                dl_done_o,
  output logic                dl_overflow_o
);

  localparam int unsigned IdxW = (PROM_CNT > 1) ? $clog2(PROM_CNT) : 1;
  localparam int unsigned CntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  // One extra bit so region ends at the top of the 25-bit space cannot wrap.
  localparam logic [25:0] RomEnd  = 26'(1) << (ROM_AW + 1);
  localparam logic [25:0] PromEnd = {1'b0, PROM_START} + (26'(PROM_CNT) << PROM_AW);

  function automatic region_e decode(input logic [24:0] addr);
    logic [25:0] a;
    a = {1'b0, addr};
    if (a < RomEnd) return RegRom;
    if (a >= PromEnd) return RegOvf;
    if (a >= {1'b0, PROM_START}) return RegProm;
    return RegGap;
  endfunction

  state_e                state_q;
  logic [CntW-1:0]       hold_cnt_q;
  logic [ROM_AW-1:0]     prog_addr_q;
  logic [7:0]            prog_data_q;
  logic [1:0]            prog_mask_q;
  logic                  prog_we_q;
  logic [PROM_AW-1:0]    prom_addr_q;
  logic [PROM_CNT-1:0]   prom_we_q;
  logic                  game_rst_q;
  logic                  dl_done_q;
  logic                  dl_overflow_q;

  region_e         region;
  logic [IdxW-1:0] prom_idx;
  logic            accept;

  always_comb begin
    region   = decode(ioctl_addr_i);
    prom_idx = IdxW'((ioctl_addr_i - PROM_START) >> PROM_AW);
    // The byte arriving on the falling edge of download is still in LOAD.
    accept   = ioctl_wr_i && (ioctl_download_i || state_q == StLoad);
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      hold_cnt_q    <= '0;
      prog_addr_q   <= '0;
      prog_data_q   <= '0;
      prog_mask_q   <= MASK_NONE;
      prog_we_q     <= 1'b0;
      prom_addr_q   <= '0;
      prom_we_q     <= '0;
      game_rst_q    <= 1'b1;
      dl_done_q     <= 1'b0;
      dl_overflow_q <= 1'b0;
    end else begin
      prog_we_q <= 1'b0;
      prom_we_q <= '0;
      dl_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (ioctl_download_i) begin
            state_q       <= StLoad;
            game_rst_q    <= 1'b1;
            dl_overflow_q <= 1'b0;
          end
        end
        StLoad: begin
          if (!ioctl_download_i) state_q <= StDrain;
        end
        StDrain: begin
          hold_cnt_q <= '0;
          if (ioctl_download_i) begin
            state_q       <= StLoad;
            dl_overflow_q <= 1'b0;
          end else begin
            state_q   <= StHold;
            dl_done_q <= 1'b1;
          end
        end
        StHold: begin
          if (ioctl_download_i) begin
            state_q       <= StLoad;
            hold_cnt_q    <= '0;
            dl_overflow_q <= 1'b0;
          end else if (hold_cnt_q == CntW'(HOLD_CYCLES)) begin
            state_q    <= StIdle;
            game_rst_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the FSM so an overflow byte on the rising edge still flags.
      if (accept) begin
        unique case (region)
          RegRom: begin
            prog_addr_q <= ioctl_addr_i[ROM_AW:1];
            prog_data_q <= ioctl_dout_i;
            prog_mask_q <= ioctl_addr_i[0] ? MASK_HI : MASK_LO;
            prog_we_q   <= 1'b1;
          end
          RegProm: begin
            prog_data_q         <= ioctl_dout_i;
            prom_addr_q         <= ioctl_addr_i[PROM_AW-1:0];
            prom_we_q[prom_idx] <= 1'b1;
          end
          RegOvf:  dl_overflow_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign prog_addr_o   = prog_addr_q;
  assign prog_data_o   = prog_data_q;
  assign prog_mask_o   = prog_mask_q;
  assign prog_we_o     = prog_we_q;
  assign prom_addr_o   = prom_addr_q;
  assign prom_we_o     = prom_we_q;
  assign game_rst_o    = game_rst_q;
  assign dl_done_o     = dl_done_q;
  assign dl_overflow_o = dl_overflow_q;

endmodule

// File: tb/tb_rom_dl_loader.sv
// Directed bench for rom_dl_loader: vector table for the address decode plus
// hand-written sequences for download end, hold window and mid-load reset.
module tb_rom_dl_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl;
  logic        wr;
  logic [24:0] addr;
  logic [7:0]  dout;
  logic [16:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_we;
  logic        game_rst;
  logic        dl_done;
  logic        dl_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rom_dl_loader dut (
    .clk_sys_i       (clk),
    .reset_i         (rst),
    .ioctl_download_i(dl),
    .ioctl_wr_i      (wr),
    .ioctl_addr_i    (addr),
    .ioctl_dout_i    (dout),
    .prog_addr_o     (prog_addr),
    .prog_data_o     (prog_data),
    .prog_mask_o     (prog_mask),
    .prog_we_o       (prog_we),
    .prom_addr_o     (prom_addr),
    .prom_we_o       (prom_we),
    .game_rst_o      (game_rst),
    .dl_done_o       (dl_done),
    .dl_overflow_o   (dl_overflow)
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [16:0] paddr;
    logic [1:0]  mask;
    logic [7:0]  pdata;
    logic [7:0]  prom_we;
    logic [7:0]  prom_addr;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the following negedge.
  task automatic send(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    wr   = 1'b1;
    addr = a;
    dout = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    int i_done;
    int i_rst;
    int n_done;

    vecs[0] = '{25'h00000, 8'hAA, 1'b1, 17'h00000, 2'b10, 8'hAA, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{25'h00001, 8'h55, 1'b1, 17'h00000, 2'b01, 8'h55, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{25'h1234F, 8'h11, 1'b1, 17'h091A7, 2'b01, 8'h11, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{25'h3FFFE, 8'h22, 1'b1, 17'h1FFFF, 2'b10, 8'h22, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{25'h40105, 8'h3C, 1'b0, 17'h1FFFF, 2'b10, 8'h3C, 8'h02, 8'h05, 1'b0};
    vecs[5] = '{25'h407FF, 8'h77, 1'b0, 17'h1FFFF, 2'b10, 8'h77, 8'h80, 8'hFF, 1'b0};
    vecs[6] = '{25'h40000, 8'h01, 1'b0, 17'h1FFFF, 2'b10, 8'h01, 8'h01, 8'h00, 1'b0};
    vecs[7] = '{25'h40800, 8'h99, 1'b0, 17'h1FFFF, 2'b10, 8'h01, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{25'h00002, 8'h33, 1'b1, 17'h00001, 2'b10, 8'h33, 8'h00, 8'h00, 1'b1};

    rst  = 1'b1;
    dl   = 1'b0;
    wr   = 1'b0;
    addr = '0;
    dout = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("reset game_rst", game_rst, 1);
    check("reset prog_we", prog_we, 0);
    check("reset prom_we", prom_we, 0);
    check("reset prog_mask", prog_mask, 2'b11);
    check("reset prog_addr", prog_addr, 0);
    check("reset prog_data", prog_data, 0);
    check("reset prom_addr", prom_addr, 0);
    check("reset dl_done", dl_done, 0);
    check("reset dl_overflow", dl_overflow, 0);

    send(25'h00000, 8'hEE);
    check("no-dl write prog_we", prog_we, 0);
    check("no-dl write prog_data", prog_data, 0);

    @(negedge clk);
    dl = 1'b1;
    for (int v = 0; v < 9; v++) begin
      send(vecs[v].addr, vecs[v].data);
      check($sformatf("v%0d prog_we", v), prog_we, vecs[v].we);
      check($sformatf("v%0d prog_addr", v), prog_addr, vecs[v].paddr);
      check($sformatf("v%0d prog_mask", v), prog_mask, vecs[v].mask);
      check($sformatf("v%0d prog_data", v), prog_data, vecs[v].pdata);
      check($sformatf("v%0d prom_we", v), prom_we, vecs[v].prom_we);
      check($sformatf("v%0d prom_addr", v), prom_addr, vecs[v].prom_addr);
      check($sformatf("v%0d dl_overflow", v), dl_overflow, vecs[v].ovf);
      @(negedge clk);
      check($sformatf("v%0d strobe width", v), {prog_we, prom_we}, 0);
    end

    // Last byte arrives on the same cycle download drops.
    @(negedge clk);
    dl   = 1'b0;
    wr   = 1'b1;
    addr = 25'h00003;
    dout = 8'h5A;
    @(negedge clk);
    wr = 1'b0;
    check("fall write prog_we", prog_we, 1);
    check("fall write prog_addr", prog_addr, 17'h00001);
    check("fall write prog_mask", prog_mask, 2'b01);
    check("fall write prog_data", prog_data, 8'h5A);
    check("fall dl_done early", dl_done, 0);

    i_done = -1;
    i_rst  = -1;
    n_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (dl_done) begin
        n_done++;
        if (i_done < 0) i_done = c;
      end
      if (!game_rst && i_rst < 0) i_rst = c;
    end
    check("dl_done pulse count", n_done, 1);
    check("dl_done timing", i_done, 1);
    check("game_rst release delay", i_rst - i_done, 17);
    check("overflow sticky after fall", dl_overflow, 1);
    check("game_rst idle low", game_rst, 0);

    @(negedge clk);
    dl = 1'b1;
    @(negedge clk);
    check("rise clears overflow", dl_overflow, 0);
    check("rise sets game_rst", game_rst, 1);

    // Reset lands while a byte is presented mid-load.
    @(negedge clk);
    wr   = 1'b1;
    addr = 25'h00010;
    dout = 8'hC3;
    #2 rst = 1'b1;
    #1;
    check("midload rst prog_mask", prog_mask, 2'b11);
    check("midload rst prog_addr", prog_addr, 0);
    check("midload rst prog_data", prog_data, 0);
    check("midload rst game_rst", game_rst, 1);
    @(negedge clk);
    check("midload rst prog_we", prog_we, 0);
    wr  = 1'b0;
    dl  = 1'b0;
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dl_done || prog_we || prom_we != 0) n_done++;
    end
    check("no activity after abort", n_done, 0);
    check("game_rst held after abort", game_rst, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
